// File: rtl/pool_stream.sv
// rtl/pool_stream.sv - lane-wise max/min/avg pooling over WIN-word groups with output FIFO
module pool_stream #(
    parameter int DW     = 8,
    parameter int LANES  = 16,
    parameter int WIN    = 2,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      DI_valid,
    output logic                      DI_ready,
    input  logic [DW*LANES-1:0]       DI,
    input  logic                      DI_last,
    output logic                      DO_valid,
    input  logic                      DO_ready,
    output logic [DW*LANES-1:0]       DO,
    output logic                      DO_last,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int LW = $clog2(WIN);
    localparam int AW = DW + LW;
    localparam int PW = $clog2(DEPTH);
    localparam int WW = DW * LANES;

    typedef enum logic [1:0] {
        OP_MAX = 2'd0,
        OP_MIN = 2'd1,
        OP_AVG = 2'd2
    } op_e;

    logic [LW-1:0]             cnt_q;
    logic [LANES-1:0][AW-1:0]  acc_q, acc_d;
    logic [1:0]                op_q, op_d;
    logic [WW-1:0]             res_d;
    logic [WW:0]               mem_q [DEPTH];
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [PW:0]               level_q;

    logic accept, close, pop, full;

    assign full     = (level_q == (PW+1)'(DEPTH));
    assign DI_ready = ~full;
    assign accept   = DI_valid & DI_ready;
    assign close    = accept & ((cnt_q == LW'(WIN - 1)) | DI_last);
    assign pop      = DO_valid & DO_ready;

    // The first word of a group seeds the accumulator and picks the operator.
    always_comb begin
        logic [AW-1:0] ext;
        logic [AW-1:0] nxt;
        logic [AW-1:0] shr;
        logic          gt;
        logic          lt;
        op_d  = (cnt_q == '0) ? mode : op_q;
        acc_d = acc_q;
        res_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (SIGNED != 0) begin
                ext = {{LW{DI[DW*k+DW-1]}}, DI[DW*k +: DW]};
                gt  = $signed(ext) > $signed(acc_q[k]);
                lt  = $signed(ext) < $signed(acc_q[k]);
            end else begin
                ext = {{LW{1'b0}}, DI[DW*k +: DW]};
                gt  = ext > acc_q[k];
                lt  = ext < acc_q[k];
            end
            if (cnt_q == '0) begin
                nxt = ext;
            end else begin
                case (op_d)
                    OP_MIN:  nxt = lt ? ext : acc_q[k];
                    OP_AVG:  nxt = acc_q[k] + ext;
                    default: nxt = gt ? ext : acc_q[k];
                endcase
            end
            // A short group still divides by WIN: missing words act as zeros.
            if (SIGNED != 0) begin
                shr = $signed(nxt) >>> LW;
            end else begin
                shr = nxt >> LW;
            end
            acc_d[k] = nxt;
            res_d[DW*k +: DW] = (op_d == OP_AVG) ? shr[DW-1:0] : nxt[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
                op_q  <= op_d;
                cnt_q <= close ? '0 : cnt_q + LW'(1);
            end
            if (close) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({close, pop})
                2'b10:   level_q <= level_q + (PW+1)'(1);
                2'b01:   level_q <= level_q - (PW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (close) begin
            mem_q[wr_ptr_q] <= {DI_last, res_d};
        end
    end

    assign DO_valid   = (level_q != '0);
    assign DO         = DO_valid ? mem_q[rd_ptr_q][WW-1:0] : '0;
    assign DO_last    = DO_valid & mem_q[rd_ptr_q][WW];
    assign fifo_level = level_q;

endmodule
